// File: rtl/vga_timing_pkg.sv
// Shared 640x480@60 VGA timing constants for the horizontal and vertical mod counters.
package vga_timing_pkg;

  localparam int WIDTH = 10;

  localparam int H_TOTAL      = 800;
  localparam int H_ACTIVE     = 640;
  localparam int H_SYNC_START = 656;
  localparam int H_SYNC_END   = 752;

  localparam int V_TOTAL      = 525;
  localparam int V_ACTIVE     = 480;
  localparam int V_SYNC_START = 490;
  localparam int V_SYNC_END   = 492;

  localparam logic SYNC_ACTIVE_LOW  = 1'b0;
  localparam logic SYNC_ACTIVE_HIGH = 1'b1;

endpackage

// File: rtl/vga_window_decode.sv
// Combinational window comparator: hit_o = POL while LO <= x_i < HI, else ~POL.
module vga_window_decode #(
  parameter int   WIDTH = 10,
  parameter int   LO    = 0,
  parameter int   HI    = 1,
  parameter logic POL   = 1'b1
) (
  input  logic [WIDTH-1:0] x_i,
  output logic             hit_o
);

  // One extra bit so HI may equal 2**WIDTH.
  localparam logic [WIDTH:0] LO_W = (WIDTH+1)'(LO);
  localparam logic [WIDTH:0] HI_W = (WIDTH+1)'(HI);

  logic [WIDTH:0] x_w;
  logic           in_win;

  assign x_w = {1'b0, x_i};

  generate
    if (LO == 0) begin : g_lo_zero
      assign in_win = (x_w < HI_W);
    end else begin : g_lo_nonzero
      assign in_win = (x_w >= LO_W) && (x_w < HI_W);
    end
  endgenerate

  assign hit_o = in_win ? POL : ~POL;

endmodule

// File: rtl/vga_mod_counter.sv
// Modulo up/down counter with load, cascade terminal count and registered
// sync/active window flags aligned with Q.
module vga_mod_counter
  import vga_timing_pkg::*;
#(
  parameter int   WIDTH      = vga_timing_pkg::WIDTH,
  parameter int   MODULUS    = H_TOTAL,
  parameter int   ACTIVE_END = H_ACTIVE,
  parameter int   SYNC_START = H_SYNC_START,
  parameter int   SYNC_END   = H_SYNC_END,
  parameter logic SYNC_POL   = SYNC_ACTIVE_LOW
) (
  input  logic             Clock,
  input  logic             Clear,
  input  logic             Count,
  input  logic             Load,
  input  logic             Up,
  input  logic [WIDTH-1:0] D,
  output logic [WIDTH-1:0] Q,
  output logic             TC,
  output logic             Sync,
  output logic             Active
);

  generate
    if (!((MODULUS >= 2) && (ACTIVE_END <= SYNC_START) && (SYNC_START < SYNC_END) &&
          (SYNC_END <= MODULUS) && (MODULUS <= 2**WIDTH))) begin : g_bad_params
      $error("vga_mod_counter: illegal timing parameters");
    end
  endgenerate

  localparam logic [WIDTH:0]   MOD_W = (WIDTH+1)'(MODULUS);
  localparam logic [WIDTH-1:0] MAX_Q = WIDTH'(MODULUS - 1);

  logic [WIDTH-1:0] q_q, q_d;
  logic             sync_q, sync_d;
  logic             active_q, active_d;
  logic             at_wrap;

  always_comb begin
    q_d = q_q;
    if (Load) begin
      q_d = ({1'b0, D} < MOD_W) ? D : '0;
    end else if (Count) begin
      if (Up) begin
        q_d = (q_q == MAX_Q) ? '0 : q_q + WIDTH'(1);
      end else begin
        q_d = (q_q == '0) ? MAX_Q : q_q - WIDTH'(1);
      end
    end
  end

  assign at_wrap = Up ? (q_q == MAX_Q) : (q_q == '0);
  assign TC      = Count & ~Load & at_wrap;

  // Windows decode the next Q so the registered flags line up with Q itself.
  vga_window_decode #(
    .WIDTH (WIDTH),
    .LO    (0),
    .HI    (ACTIVE_END),
    .POL   (1'b1)
  ) u_active_dec (
    .x_i   (q_d),
    .hit_o (active_d)
  );

  vga_window_decode #(
    .WIDTH (WIDTH),
    .LO    (SYNC_START),
    .HI    (SYNC_END),
    .POL   (SYNC_POL)
  ) u_sync_dec (
    .x_i   (q_d),
    .hit_o (sync_d)
  );

  always_ff @(posedge Clock or posedge Clear) begin
    if (Clear) begin
      q_q      <= '0;
      sync_q   <= ~SYNC_POL;
      active_q <= 1'b1;
    end else begin
      q_q      <= q_d;
      sync_q   <= sync_d;
      active_q <= active_d;
    end
  end

  assign Q      = q_q;
  assign Sync   = sync_q;
  assign Active = active_q;

endmodule
